// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
// Module   : control_seq
// Brief    : Multi-cycle FETCH/EXEC instruction sequencer with memory stall.
// Revision : 1.0 - initial release
// ============================================================================
module control_seq #(
    parameter int INST_W     = 8,
    parameter int CYC_W      = 2,
    parameter int MEM_CYCLES = 2,
    parameter int RS_W       = 2,
    parameter int ALU_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst_in,
    input  logic              inst_valid,
    input  logic              mem_ready,
    input  logic              carry_in,
    output logic              fetch_req,
    output logic [INST_W-1:0] inst,
    output logic [CYC_W-1:0]  cycle,
    output logic              MC,
    output logic [RS_W-1:0]   RS,
    output logic [ALU_W-1:0]  ALU,
    output logic              carry,
    output logic              busy,
    output logic              done
);

    localparam logic [0:0]       c_FETCH    = 1'b0;
    localparam logic [0:0]       c_EXEC     = 1'b1;
    localparam logic [CYC_W-1:0] c_MEM_LAST = CYC_W'(MEM_CYCLES - 1);

    logic [0:0]        r_state;
    logic [INST_W-1:0] r_ir;
    logic [CYC_W-1:0]  r_cycle;
    logic              r_carry;

    logic              w_exec;
    logic              w_mem_class;
    logic [CYC_W-1:0]  w_last;
    logic              w_stall;

    assign w_exec      = (r_state == c_EXEC);
    assign w_mem_class = r_ir[INST_W-1];
    // Index of the final EXEC cycle: L-1
    assign w_last      = w_mem_class ? c_MEM_LAST : '0;

    assign MC      = w_mem_class & (r_cycle == '0) & w_exec;
    assign w_stall = MC & ~mem_ready;
    assign done    = w_exec & ~w_stall & (r_cycle == w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_FETCH;
            r_ir    <= '0;
            r_cycle <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (inst_valid) begin
                        r_ir    <= inst_in;
                        r_cycle <= '0;
                        r_state <= c_EXEC;
                    end
                end
                default: begin
                    if (done) begin
                        r_state <= c_FETCH;
                        r_cycle <= '0;
                        if (!w_mem_class) begin
                            r_carry <= carry_in;
                        end
                    end else if (!w_stall) begin
                        r_cycle <= r_cycle + CYC_W'(1);
                    end
                end
            endcase
        end
    end

    assign fetch_req = ~w_exec;
    assign busy      = w_exec;
    assign inst      = r_ir;
    assign cycle     = r_cycle;
    assign carry     = r_carry;
    assign RS        = r_ir[RS_W-1:0];
    assign ALU       = r_ir[ALU_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_seq
// Brief    : Self-checking bench for control_seq (default and 8-cycle builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] inst_in;
    logic       inst_valid;
    logic       mem_ready;
    logic       carry_in;

    logic       fetch_req, MC, carry, busy, done;
    logic [7:0] inst;
    logic [1:0] cycle;
    logic [1:0] RS;
    logic [3:0] ALU;

    logic       fetch_req8, MC8, carry8, busy8, done8;
    logic [7:0] inst8;
    logic [2:0] cycle8;
    logic [1:0] RS8;
    logic [3:0] ALU8;

    int checks   = 0;
    int failures = 0;

    control_seq dut (
        .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .inst_valid(inst_valid),
        .mem_ready(mem_ready), .carry_in(carry_in), .fetch_req(fetch_req),
        .inst(inst), .cycle(cycle), .MC(MC), .RS(RS), .ALU(ALU),
        .carry(carry), .busy(busy), .done(done)
    );

    control_seq #(.CYC_W(3), .MEM_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .inst_valid(inst_valid),
        .mem_ready(mem_ready), .carry_in(carry_in), .fetch_req(fetch_req8),
        .inst(inst8), .cycle(cycle8), .MC(MC8), .RS(RS8), .ALU(ALU8),
        .carry(carry8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction occupies L EXEC cycles, L from its class.
    int         MEMC [2] = '{2, 8};
    bit         m_exec  [2];
    logic [7:0] m_ir    [2];
    int         m_n     [2];
    bit         m_carry [2];

    function automatic int len_of(input int k);
        return m_ir[k][7] ? MEMC[k] : 1;
    endfunction

    function automatic bit exp_mc(input int k);
        return m_exec[k] && m_ir[k][7] && (m_n[k] == 0);
    endfunction

    function automatic bit exp_done(input int k);
        return m_exec[k] && !(exp_mc(k) && !mem_ready) && (m_n[k] == len_of(k) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_exec[k]  <= 1'b0;
                m_ir[k]    <= 8'h00;
                m_n[k]     <= 0;
                m_carry[k] <= 1'b0;
            end else if (!m_exec[k]) begin
                if (inst_valid) begin
                    m_exec[k] <= 1'b1;
                    m_ir[k]   <= inst_in;
                    m_n[k]    <= 0;
                end
            end else if (exp_done(k)) begin
                m_exec[k] <= 1'b0;
                m_n[k]    <= 0;
                if (!m_ir[k][7]) m_carry[k] <= carry_in;
            end else if (!(exp_mc(k) && !mem_ready)) begin
                m_n[k] <= m_n[k] + 1;
            end
        end
    end

    task automatic cmp(input int k, input logic fr, input logic [7:0] in_v,
                       input logic [31:0] cy, input logic mc, input logic [1:0] rs,
                       input logic [3:0] alu, input logic cr, input logic bz,
                       input logic dn);
        string p;
        p = (k == 0) ? "d2" : "d8";
        check({p, "_fetch_req"}, fr, !m_exec[k]);
        check({p, "_busy"}, bz, m_exec[k]);
        check({p, "_inst"}, in_v, m_ir[k]);
        check({p, "_cycle"}, cy, m_n[k]);
        check({p, "_MC"}, mc, exp_mc(k));
        check({p, "_done"}, dn, exp_done(k));
        check({p, "_RS"}, rs, m_ir[k] % 4);
        check({p, "_ALU"}, alu, m_ir[k] % 16);
        check({p, "_carry"}, cr, m_carry[k]);
    endtask

    always @(negedge clk) begin
        cmp(0, fetch_req, inst, 32'(cycle), MC, RS, ALU, carry, busy, done);
        cmp(1, fetch_req8, inst8, 32'(cycle8), MC8, RS8, ALU8, carry8, busy8, done8);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        inst_valid = 1'b0;
        mem_ready  = 1'b1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (fetch_req && fetch_req8) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; inst_in = 8'h00; inst_valid = 1'b0; mem_ready = 1'b0; carry_in = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("rst_fetch_req", fetch_req, 1);
        check("rst_inst", inst, 8'h00);
        check("rst_carry", carry, 0);

        // ALU-class op
        inst_in = 8'h2B; inst_valid = 1'b1; carry_in = 1'b1;
        step();
        inst_valid = 1'b0;
        @(negedge clk);
        check("alu_busy", busy, 1);
        check("alu_RS", RS, 2'd3);
        check("alu_ALU", ALU, 4'hB);
        check("alu_MC", MC, 0);
        check("alu_done", done, 1);
        step();
        check("alu_carry", carry, 1);
        check("alu_fetch_req", fetch_req, 1);
        carry_in = 1'b0;

        // Memory-class op with three stalled cycles
        inst_in = 8'h86; inst_valid = 1'b1; mem_ready = 1'b0;
        step();
        inst_valid = 1'b0;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (cnt <= 4) begin
                check("mem_cycle0", cycle, 0);
                check("mem_MC0", MC, 1);
                check("mem_done0", done, 0);
            end else begin
                check("mem_cycle1", cycle, 1);
                check("mem_MC1", MC, 0);
                check("mem_done1", done, 1);
            end
            step();
            if (cnt == 3) mem_ready = 1'b1;
        end
        check("mem_total_clocks", cnt + 1, 6);
        check("mem_carry_kept", carry, 1);
        check("mem_fetch_req", fetch_req, 1);

        // Fetch wait: IR holds
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("wait_inst", inst, 8'h86);
            check("wait_fetch_req", fetch_req, 1);
            step();
        end

        // inst_valid during EXEC is ignored
        inst_in = 8'h2B; inst_valid = 1'b1;
        step();
        inst_in = 8'hFF;
        step();
        inst_valid = 1'b0;
        @(negedge clk);
        check("exec_valid_ignored", inst, 8'h2B);
        check("exec_valid_fetch", fetch_req, 1);

        // Eight-cycle memory op on the wide build
        wait_idle();
        inst_in = 8'hC0; inst_valid = 1'b1; mem_ready = 1'b1;
        step();
        inst_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("d8_run_cycle", cycle8, i);
            check("d8_run_done", done8, (i == 7));
            check("d8_run_MC", MC8, (i == 0));
            step();
        end
        @(negedge clk);
        check("d8_run_fetch", fetch_req8, 1);

        // Random traffic, checked by the compare process
        for (int t = 0; t < 600; t++) begin
            step();
            inst_in    = 8'($urandom);
            inst_valid = 1'($urandom_range(0, 1));
            mem_ready  = ($urandom_range(0, 3) != 0);
            carry_in   = 1'($urandom_range(0, 1));
        end

        // Reset mid-EXEC of 0x85 at cycle 1
        wait_idle();
        inst_in = 8'h85; inst_valid = 1'b1; mem_ready = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        check("pre_rst_cycle", cycle, 1);
        rst_n = 1'b0;
        #1;
        check("arst_fetch_req", fetch_req, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_MC", MC, 0);
        check("arst_RS", RS, 0);
        check("arst_ALU", ALU, 0);
        check("arst_inst", inst, 0);
        check("arst_cycle", cycle, 0);
        check("arst_carry", carry, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_fetch_req", fetch_req, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_seq.md
# control_seq

Parametrised multi-cycle instruction sequencer for the Nandy CPU; successor to the single-cycle `control` decoder. Holds the instruction register, cycle counter and carry flag, runs a FETCH/EXEC state machine with a memory-ready stall, and drives the datapath strobes. Sits between the instruction-memory port and the ALU/register-file datapath.

## Interface
- `INST_W`, 8, instruction width; MSB = memory-class bit.
- `CYC_W`, 2, cycle-counter width.
- `MEM_CYCLES`, 2, EXEC length of memory-class instructions, legal range 2..2^CYC_W.
- `RS_W`, 2, register-select width, taken from IR[RS_W-1:0].
- `ALU_W`, 4, ALU-op width, taken from IR[ALU_W-1:0].

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_in`  in  INST_W  fetched instruction.
- `inst_valid`  in  1  `inst_in` valid this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `carry_in`  in  1  ALU carry-out.
- `fetch_req`  out  1  sequencer wants an instruction.
- `inst`  out  INST_W  instruction register.
- `cycle`  out  CYC_W  current EXEC cycle index.
- `MC`  out  1  memory-cycle strobe.
- `RS`  out  RS_W  register select.
- `ALU`  out  ALU_W  ALU opcode.
- `carry`  out  1  registered carry flag.
- `busy`  out  1  state is EXEC.
- `done`  out  1  instruction retires this cycle.

## Operation
- Two states: FETCH, EXEC. Reset state FETCH.
- Length L = 1 if IR[INST_W-1]=0 (ALU class), else MEM_CYCLES (memory class).
- FETCH: `fetch_req`=1. On edge with `inst_valid`=1: IR <= `inst_in`, `cycle` <= 0, go EXEC. Otherwise hold; IR unchanged.
- EXEC: `fetch_req`=0, `busy`=1.
  - `MC` = IR[INST_W-1] & (`cycle`==0) & EXEC.
  - Stall: `MC`=1 and `mem_ready`=0 -> hold state and `cycle`; `done`=0.
  - Advance: if `cycle` < L-1, `cycle` <= `cycle`+1; if `cycle`==L-1, `done`=1 (combinational), go FETCH, `cycle` <= 0.
  - Retire of ALU-class instruction: `carry` <= `carry_in` on that edge. Memory-class retire leaves `carry` unchanged.
- `RS`, `ALU` = IR low bits, continuously (all states).
- `inst_valid` ignored in EXEC; `mem_ready` ignored when `MC`=0.
- Counter arithmetic unsigned CYC_W bits; no wrap occurs, since L-1 ≤ 2^CYC_W-1.

## Timing
- Reset (asserted, any state, including mid-EXEC or mid-stall): immediately IR=0, `cycle`=0, `carry`=0, state FETCH. Hence `fetch_req`=1, `busy`=0, `done`=0, `MC`=0, `RS`=0, `ALU`=0.
- Release of `rst_n` is synchronised externally. First fetch can be accepted on the first edge after release.
- ALU instruction: 2 clocks (FETCH accept + 1 EXEC), `done` in the EXEC clock.
- Memory instruction, no stall: 1 + MEM_CYCLES clocks; each stalled cycle adds 1 clock.
- FETCH always lasts ≥1 clock between instructions (no back-to-back EXEC).
- `done` and `MC` are combinational from registered state plus `mem_ready`; no input-to-output path except `mem_ready` -> `done` and `mem_ready` -> `cycle` advance.

## Test plan
- Reset: drive `rst_n`=0 mid-EXEC of 0x85 at `cycle`=1 -> all outputs to reset values the same cycle; `fetch_req`=1 after release.
- ALU op: `inst_in`=0x2B with valid, `carry_in`=1 -> next clock `busy`=1, `RS`=3, `ALU`=0xB, `MC`=0, `done`=1. Following clock `carry`=1, `fetch_req`=1.
- Memory op, ready: 0x86, `mem_ready`=1 -> `cycle` 0 (`MC`=1), then `cycle` 1 (`MC`=0, `done`=1). `carry` unchanged.
- Memory stall: 0x86, `mem_ready` low 3 clocks -> `cycle` holds 0 and `MC`=1 for 3 clocks, advancing on the 4th. Total 6 clocks fetch-to-FETCH.
- Fetch wait: `inst_valid`=0 for 5 clocks -> IR holds its prior value, `fetch_req`=1 throughout. A `inst_valid` pulse during EXEC is ignored.
- Parametrised: CYC_W=3, MEM_CYCLES=8, op 0xC0 -> `cycle` runs 0..7, `done` on `cycle`=7, no counter wrap.
